pll_lock_sequencer: RTL and testbench

// Sequences bring-up of the iCE40 SB_PLL40_CORE pixel-clock PLL (12 MHz ref -> 31.5 MHz). Drives the PLL's active-low

---
 rtl/pll_seq_pkg.sv | 25 ++
 rtl/bit_synchronizer.sv | 25 ++
 rtl/pll_lock_sequencer.sv | 152 +++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and default timing for the PLL bring-up sequencer.
// Defaults target a 12 MHz reference driving an iCE40 SB_PLL40_CORE.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } state_t;

  localparam int DEF_RESET_CYCLES = 12;
  localparam int DEF_LOCK_TIMEOUT = 1200;
  localparam int DEF_LOCK_STABLE  = 64;
  localparam int DEF_MAX_RETRIES  = 3;
  localparam int DEF_CNT_W        = 16;

  // Width needed to count 0..max_retries, never narrower than one bit.
  function automatic int retry_w(input int max_retries);
    return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Two-flop synchronizer for a single level signal crossing into clk_i.
// Output follows the input with two cycles of latency; resets to 0.
module bit_synchronizer (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Brings up the pixel-clock PLL: pulses RESETB, waits for lock with timeout and retry,
// qualifies lock stability, then releases the pixel-domain reset; re-sequences on lock loss.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
  parameter int MAX_RETRIES  = DEF_MAX_RETRIES,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int RETRY_W      = retry_w(MAX_RETRIES)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enable_i,
  input  logic               clear_status_i,
  input  logic               pll_lock_i,
  output logic               pll_resetb_o,
  output logic               domain_reset_o,
  output logic               ready_o,
  output logic               fault_o,
  output logic               lock_lost_o,
  output logic [RETRY_W-1:0] retry_count_o
);

  logic lock_s;

  bit_synchronizer u_lock_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (pll_lock_i),
    .q_o   (lock_s)
  );

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               lock_lost_q, lock_lost_d;
  logic               pll_resetb_q, pll_resetb_d;
  logic               domain_reset_q, domain_reset_d;
  logic               ready_q, ready_d;
  logic               fault_q, fault_d;
  logic               attempt_fail;
  logic               lost_set;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    retry_d      = retry_q;
    attempt_fail = 1'b0;
    lost_set     = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable_i) begin
          state_d = HOLD;
          retry_d = '0;
        end
      end
      HOLD: begin
        if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          attempt_fail = 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          attempt_fail = 1'b1;
        end else if (cnt_q == CNT_W'(LOCK_STABLE - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!lock_s) begin
          lost_set = 1'b1;
          retry_d  = '0;
          state_d  = HOLD;
        end
      end
      FAULT: cnt_d = '0;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (attempt_fail) begin
      cnt_d = '0;
      if (retry_q < RETRY_W'(MAX_RETRIES)) begin
        retry_d = retry_q + RETRY_W'(1);
        state_d = HOLD;
      end else begin
        state_d = FAULT;
      end
    end

    // Shutdown wins over every lock event, including a loss seen in RUN.
    if (!enable_i) begin
      state_d  = IDLE;
      cnt_d    = '0;
      retry_d  = retry_q;
      lost_set = 1'b0;
    end

    lock_lost_d    = lost_set | (lock_lost_q & ~clear_status_i);
    pll_resetb_d   = (state_d == WAIT_LOCK) || (state_d == STABLE) || (state_d == RUN);
    domain_reset_d = (state_d != RUN);
    ready_d        = (state_d == RUN);
    fault_d        = (state_d == FAULT);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      retry_q        <= '0;
      lock_lost_q    <= 1'b0;
      pll_resetb_q   <= 1'b0;
      domain_reset_q <= 1'b1;
      ready_q        <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      retry_q        <= retry_d;
      lock_lost_q    <= lock_lost_d;
      pll_resetb_q   <= pll_resetb_d;
      domain_reset_q <= domain_reset_d;
      ready_q        <= ready_d;
      fault_q        <= fault_d;
    end
  end

  assign pll_resetb_o   = pll_resetb_q;
  assign domain_reset_o = domain_reset_q;
  assign ready_o        = ready_q;
  assign fault_o        = fault_q;
  assign lock_lost_o    = lock_lost_q;
  assign retry_count_o  = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed bring-up scenarios plus random
// stimulus, every cycle compared against a phase/elapsed-time model of the sequencer.
module tb_pll_lock_sequencer;

  localparam int RESET_CYCLES = 12;
  localparam int LOCK_TIMEOUT = 1200;
  localparam int LOCK_STABLE  = 64;
  localparam int MAX_RETRIES  = 3;

  localparam int P_IDLE = 0, P_HOLD = 1, P_WAIT = 2, P_STABLE = 3, P_RUN = 4, P_FAULT = 5;

  logic       clk = 1'b0;
  logic       rst, en, clr, lock;
  logic       pll_resetb, domain_reset, ready, fault, lock_lost;
  logic [1:0] retry_count;

  always #5 clk = ~clk;

  pll_lock_sequencer dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .enable_i       (en),
    .clear_status_i (clr),
    .pll_lock_i     (lock),
    .pll_resetb_o   (pll_resetb),
    .domain_reset_o (domain_reset),
    .ready_o        (ready),
    .fault_o        (fault),
    .lock_lost_o    (lock_lost),
    .retry_count_o  (retry_count)
  );

  // Reference model: which phase the bring-up is in and how long it has been there.
  int m_phase, m_t, m_fails;
  bit m_lost;
  bit hist0, hist1;
  bit ls, fail, lset;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = P_IDLE; m_t = 0; m_fails = 0; m_lost = 0; hist0 = 0; hist1 = 0;
    end else begin
      ls = hist1;               // lock value as seen two edges after it was sampled
      hist1 = hist0; hist0 = lock;
      fail = 0; lset = 0;
      if (!en) begin
        m_phase = P_IDLE; m_t = 0;
      end else begin
        case (m_phase)
          P_IDLE: begin m_phase = P_HOLD; m_t = 0; m_fails = 0; end
          P_HOLD: begin
            m_t++;
            if (m_t == RESET_CYCLES) begin m_phase = P_WAIT; m_t = 0; end
          end
          P_WAIT: begin
            if (ls) begin m_phase = P_STABLE; m_t = 0; end
            else begin m_t++; if (m_t == LOCK_TIMEOUT) fail = 1; end
          end
          P_STABLE: begin
            if (!ls) fail = 1;
            else begin m_t++; if (m_t == LOCK_STABLE) begin m_phase = P_RUN; m_t = 0; end end
          end
          P_RUN: if (!ls) begin lset = 1; m_fails = 0; m_phase = P_HOLD; m_t = 0; end
          default: ;
        endcase
        if (fail) begin
          m_t = 0;
          if (m_fails < MAX_RETRIES) begin m_fails++; m_phase = P_HOLD; end
          else m_phase = P_FAULT;
        end
      end
      m_lost = lset | (m_lost & !clr);
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_assert++;
    n_fail++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  task automatic check_model();
    chk("model_resetb", pll_resetb, (m_phase == P_WAIT || m_phase == P_STABLE || m_phase == P_RUN));
    chk("model_domain_reset", domain_reset, (m_phase != P_RUN));
    chk("model_ready", ready, (m_phase == P_RUN));
    chk("model_fault", fault, (m_phase == P_FAULT));
    chk("model_lock_lost", lock_lost, m_lost);
    chk("model_retry", retry_count, m_fails);
  endtask

  task automatic tick();
    @(negedge clk);
    check_model();
  endtask

  // Ticks until pll_resetb shows v; n = ticks taken.
  task automatic wait_resetb(input logic v, input int budget, input string name, output int n);
    n = 0;
    while (1) begin
      tick(); n++;
      if (pll_resetb === v) break;
      if (n >= budget) begin timeout_fail(name); break; end
    end
  endtask

  task automatic wait_ready(input int budget, input string name, output int n);
    n = 0;
    while (1) begin
      tick(); n++;
      if (ready === 1'b1) break;
      if (n >= budget) begin timeout_fail(name); break; end
    end
  endtask

  task automatic restart(input logic lock_v);
    en = 0; lock = lock_v;
    tick(); tick(); tick();
    en = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rises, seen_ready;
    logic prev;
    rst = 1; en = 0; clr = 0; lock = 0;
    repeat (2) @(negedge clk);
    chk("rst_resetb", pll_resetb, 0);
    chk("rst_domain_reset", domain_reset, 1);
    chk("rst_ready", ready, 0);
    chk("rst_fault", fault, 0);
    chk("rst_lock_lost", lock_lost, 0);
    chk("rst_retry", retry_count, 0);
    rst = 0;
    tick();

    // Clean lock: first tick after enable is the IDLE->HOLD edge, so HOLD spans n-1 ticks.
    en = 1;
    wait_resetb(1, 100, "clean_hold", n);
    chk("clean_hold_len", n - 1, 12);
    repeat (99) tick();
    lock = 1;
    // First tick covers the edge that samples lock; ready lands 2+64 edges after it.
    wait_ready(200, "clean_ready", n);
    chk("clean_lock_to_ready", n - 1, 66);
    chk("clean_retry", retry_count, 0);
    chk("clean_domain_reset", domain_reset, 0);

    // Loss in RUN, with clear pulsed on the very edge that sets LOCK_LOST.
    lock = 0;
    tick(); tick();
    clr = 1;
    tick();
    clr = 0;
    chk("loss_ready", ready, 0);
    chk("loss_domain_reset", domain_reset, 1);
    chk("loss_lock_lost_set_wins", lock_lost, 1);
    chk("loss_resetb", pll_resetb, 0);
    repeat (20) tick();
    chk("loss_still_sticky", lock_lost, 1);
    clr = 1; tick(); clr = 0;
    chk("loss_cleared", lock_lost, 0);

    // Timeout on first attempt, lock on second.
    restart(0);
    wait_resetb(1, 100, "to_first_hold", n);
    wait_resetb(0, 1300, "to_wait", n);
    chk("to_wait_len", n, 1200);
    chk("to_retry_after_fail", retry_count, 1);
    wait_resetb(1, 100, "to_rehold", n);
    chk("to_rehold_len", n, 12);
    lock = 1;
    wait_ready(200, "to_ready", n);
    chk("to_retry_in_run", retry_count, 1);

    // Stuck-low lock ends in FAULT after MAX_RETRIES+1 RESETB pulses.
    restart(0);
    rises = 0; prev = pll_resetb; n = 0;
    while (fault !== 1'b1) begin
      tick(); n++;
      if (pll_resetb === 1'b1 && prev === 1'b0) rises++;
      prev = pll_resetb;
      if (n > 6000) begin timeout_fail("fault_wait"); break; end
    end
    chk("fault_pulses", rises, 4);
    chk("fault_flag", fault, 1);
    chk("fault_retry", retry_count, 3);
    chk("fault_resetb", pll_resetb, 0);
    repeat (30) tick();
    chk("fault_sticks", fault, 1);
    en = 0; tick();
    chk("fault_exit", fault, 0);
    chk("fault_exit_resetb", pll_resetb, 0);

    // One-cycle lock glitch around STABLE count 30.
    lock = 1;
    restart(1);
    wait_resetb(1, 100, "gl_hold", n);
    repeat (29) tick();
    lock = 0; tick(); lock = 1;
    seen_ready = 0;
    repeat (10) begin tick(); if (ready === 1'b1) seen_ready = 1; end
    chk("gl_no_run", seen_ready, 0);
    chk("gl_retry", retry_count, 1);
    chk("gl_back_to_hold", pll_resetb, 0);

    // Async reset in the middle of WAIT_LOCK.
    restart(0);
    wait_resetb(1, 100, "ar_hold", n);
    repeat (50) tick();
    #3 rst = 1;
    #1;
    chk("ar_resetb", pll_resetb, 0);
    chk("ar_domain_reset", domain_reset, 1);
    chk("ar_ready", ready, 0);
    chk("ar_retry", retry_count, 0);
    chk("ar_lock_lost", lock_lost, 0);
    tick();
    rst = 0;
    wait_resetb(1, 100, "ar_rehold", n);
    chk("ar_rehold_len", n - 1, 12);

    // ENABLE dropped while in STABLE.
    lock = 1;
    repeat (20) tick();
    chk("en_in_stable_not_ready", ready, 0);
    en = 0; tick();
    chk("en_off_resetb", pll_resetb, 0);
    chk("en_off_domain_reset", domain_reset, 1);
    en = 1;
    wait_resetb(1, 100, "en_rehold", n);
    chk("en_rehold_len", n - 1, 12);

    // Random stimulus against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) lock = ~lock;
      en  = ($urandom_range(0, 399) != 0);
      clr = ($urandom_range(0, 39) == 0);
      tick();
    end
    en = 0; clr = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
